// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix row scanner that locks onto a pressed key and reports debounced key codes
module keypad_scanner #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       req,
    output logic [3:0] activeCol,
    input  logic       high,
    input  logic       low,
    output logic [3:0] key,
    output logic       keyValid,
    output logic       pressed
);
    localparam logic [1:0] SCAN    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;
    localparam logic [3:0] SETTLE_N = 4'(SETTLE);
    // Key codes packed by {row, col}: nibble 0 is row 0 / col 0.
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    logic [1:0] state;
    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic [3:0] settle;
    logic [1:0] low_col;

    assign low_col   = col[0] ? 2'd0 : col[1] ? 2'd1 : col[2] ? 2'd2 : 2'd3;
    assign req       = (state == CONFIRM) || (state == HELD);
    assign row       = 4'b0001 << row_idx;
    assign activeCol = req ? ~(4'b0001 << col_idx) : 4'b1111;

    // Scan / confirm / held sequencing with registered key code, strobe and held flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= SCAN;
            row_idx  <= 2'd0;
            col_idx  <= 2'd0;
            settle   <= 4'd0;
            key      <= 4'h0;
            keyValid <= 1'b0;
            pressed  <= 1'b0;
        end else begin
            keyValid <= 1'b0;
            case (state)
                SCAN: begin
                    if (en) begin
                        if (settle < SETTLE_N) begin
                            settle <= settle + 4'd1;
                        end else if (|col) begin
                            col_idx <= low_col;
                            state   <= CONFIRM;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                            settle  <= 4'd0;
                        end
                    end
                end
                CONFIRM: begin
                    if (low) begin
                        settle <= 4'd0;
                        state  <= SCAN;
                    end else if (high) begin
                        key      <= KEY_MAP[{row_idx, col_idx, 2'b00} +: 4];
                        keyValid <= 1'b1;
                        pressed  <= 1'b1;
                        state    <= HELD;
                    end
                end
                HELD: begin
                    if (low) begin
                        pressed <= 1'b0;
                        row_idx <= row_idx + 2'd1;
                        settle  <= 4'd0;
                        state   <= SCAN;
                    end
                end
                default: begin
                    state    <= SCAN;
                    row_idx  <= 2'd0;
                    col_idx  <= 2'd0;
                    settle   <= 4'd0;
                    key      <= 4'h0;
                    keyValid <= 1'b0;
                    pressed  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix + debouncer model driving the scanner, scoreboarded key codes
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic [3:0] col;
    logic [3:0] row;
    logic       req;
    logic [3:0] activeCol;
    logic       high;
    logic       low;
    logic [3:0] key;
    logic       keyValid;
    logic       pressed;

    logic [15:0] keys = 16'h0;
    logic [2:0]  cnt_hi = 3'd0;
    logic [2:0]  cnt_lo = 3'd0;
    logic        sense;
    logic        kv_prev = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          kv_count = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  kmap[16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner #(.SETTLE(2)) dut (
        .clk(clk), .rstn(rstn), .en(en), .col(col), .row(row), .req(req),
        .activeCol(activeCol), .high(high), .low(low), .key(key),
        .keyValid(keyValid), .pressed(pressed)
    );

    always #5 clk = ~clk;

    // Key matrix: keys[r*4+c] closed connects row r to column c
    assign col = (row == 4'b0001) ? keys[3:0] :
                 (row == 4'b0010) ? keys[7:4] :
                 (row == 4'b0100) ? keys[11:8] :
                 (row == 4'b1000) ? keys[15:12] : 4'h0;

    // Debouncer model, THRESHOLD = 4: level after 5 stable en ticks, cleared while req is low
    assign sense = |(col & ~activeCol);
    assign high  = (cnt_hi == 3'd5);
    assign low   = (cnt_lo == 3'd5);
    always_ff @(posedge clk) begin
        if (!req) begin
            cnt_hi <= 3'd0;
            cnt_lo <= 3'd0;
        end else if (en) begin
            cnt_hi <= sense ? ((cnt_hi == 3'd5) ? 3'd5 : cnt_hi + 3'd1) : 3'd0;
            cnt_lo <= sense ? 3'd0 : ((cnt_lo == 3'd5) ? 3'd5 : cnt_lo + 3'd1);
        end
    end

    // Scan tick: one clk wide, every 4th clk
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 en = 1'b1;
            @(posedge clk);
            #1 en = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every keyValid strobe pops one expected key code
    always @(negedge clk) begin
        if (keyValid === 1'b1) begin
            kv_count++;
            if (kv_prev) begin
                n_checks++;
                $display("FAIL keyValid_width: got strobe two cycles in a row expected one cycle");
            end else if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_keyValid: got key %h expected no strobe", key);
            end else begin
                check("key_code", 32'(key), 32'(exp_q.pop_front()));
            end
        end
        kv_prev = keyValid;
    end

    task automatic tick();
        int i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (en !== 1'b1 && i < 20);
        #2;
    endtask

    task automatic wait_pressed(input logic v);
        for (int i = 0; i < 1000 && pressed !== v; i++) @(negedge clk);
        check("pressed_wait", 32'(pressed), 32'(v));
    endtask

    task automatic wait_req(input logic v);
        for (int i = 0; i < 1000 && req !== v; i++) @(negedge clk);
        check("req_wait", 32'(req), 32'(v));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] er;
        #3;
        check("rst_row", 32'(row), 32'h1);
        check("rst_req", 32'(req), 32'h0);
        check("rst_activeCol", 32'(activeCol), 32'hF);
        check("rst_key", 32'(key), 32'h0);
        check("rst_keyValid", 32'(keyValid), 32'h0);
        check("rst_pressed", 32'(pressed), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick();
            if (k % 3 == 0) begin
                er = 4'b0001 << ((k / 3) % 4);
                check("idle_row", 32'(row), 32'(er));
                check("idle_req", 32'(req), 32'h0);
            end
        end
        check("idle_kv", 32'(kv_count), 32'd0);

        exp_q.push_back(4'h6);
        keys[6] = 1'b1;
        wait_pressed(1'b1);
        check("k6_activeCol", 32'(activeCol), 32'hB);
        check("k6_req", 32'(req), 32'h1);
        check("k6_key", 32'(key), 32'h6);
        repeat (20) tick();
        check("k6_held", 32'(pressed), 32'h1);
        check("k6_kv", 32'(kv_count), 32'd1);
        keys = 16'h0;
        wait_pressed(1'b0);
        check("k6_next_row", 32'(row), 32'h4);
        check("k6_req_off", 32'(req), 32'h0);
        check("k6_key_kept", 32'(key), 32'h6);

        keys[0] = 1'b1;
        wait_req(1'b1);
        keys = 16'h0;
        check("bounce_row", 32'(row), 32'h1);
        check("bounce_activeCol", 32'(activeCol), 32'hE);
        wait_req(1'b0);
        check("bounce_row_kept", 32'(row), 32'h1);
        check("bounce_key", 32'(key), 32'h6);
        check("bounce_pressed", 32'(pressed), 32'h0);
        check("bounce_kv", 32'(kv_count), 32'd1);

        exp_q.push_back(4'h0);
        keys[13] = 1'b1;
        keys[15] = 1'b1;
        wait_pressed(1'b1);
        check("two_activeCol", 32'(activeCol), 32'hD);
        check("two_key", 32'(key), 32'h0);
        keys[12] = 1'b1;
        repeat (10) tick();
        check("two_kv", 32'(kv_count), 32'd2);
        keys = 16'h0;
        wait_pressed(1'b0);

        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(kmap[i]);
            keys = 16'h1 << i;
            wait_pressed(1'b1);
            check("sweep_key", 32'(key), 32'(kmap[i]));
            keys = 16'h0;
            wait_pressed(1'b0);
        end
        check("sweep_kv", 32'(kv_count), 32'd18);

        exp_q.push_back(4'h9);
        keys[10] = 1'b1;
        wait_pressed(1'b1);
        #2 rstn = 1'b0;
        #1;
        check("arst_row", 32'(row), 32'h1);
        check("arst_req", 32'(req), 32'h0);
        check("arst_pressed", 32'(pressed), 32'h0);
        check("arst_activeCol", 32'(activeCol), 32'hF);
        check("arst_key", 32'(key), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        exp_q.push_back(4'h9);
        wait_pressed(1'b1);
        check("redetect_key", 32'(key), 32'h9);
        keys = 16'h0;
        wait_pressed(1'b0);
        check("final_kv", 32'(kv_count), 32'd20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
